voter_tally: RTL
================

VOTER_TALLY -- requirements
Module: voter_tally

Interface
REQ-001 N, default 4, number of voters; legal range 1..32.
REQ-002 TIMEOUT, default 16, maximum OPEN-state cycles before forced close; legal range >= 1.
REQ-003 CW, derived as clog2(N+1), width of all count outputs.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  opens a new voting session.
REQ-007 close  input  1  requests early close of the open session.
REQ-008 vote_valid  input  N  per-voter ballot strobe.
REQ-009 vote_yes  input  N  per-voter ballot value (1 = yes, 0 = no), sampled with vote_valid.
REQ-010 busy  output  1  high while state is OPEN.
REQ-011 done  output  1  high while state is DONE.
REQ-012 yes_cnt / no_cnt / abstain_cnt  output  CW each  session tallies.
REQ-013 O  output  [3:1]  verdict, one-hot: O[3] = pass, O[2] = tie, O[1] = fail.

Function
REQ-014 FSM has three states: IDLE, OPEN, DONE; all outputs are registered.
REQ-015 IDLE with start=1 -> OPEN on the next edge; this clears the voted mask, yes_cnt, no_cnt, and the timer.
REQ-016 DONE with start=1 -> OPEN on the next edge with the same clearing; otherwise DONE holds all outputs.
REQ-017 start asserted while OPEN is ignored.
REQ-018 OPEN, per cycle: each voter i with vote_valid[i]=1 and voted[i]=0 sets voted[i] and increments yes_cnt if vote_yes[i]=1, else no_cnt.
REQ-019 Several voters in the same cycle are all counted in that cycle.
REQ-020 vote_valid from a voter already marked voted is ignored; the first ballot stands.
REQ-021 vote_valid is ignored in IDLE and DONE, including the cycle in which start is sampled.
REQ-022 Timer counts OPEN cycles from 0.
REQ-023 Close condition: close=1, or all N voted after this cycle's updates, or timer == TIMEOUT-1.
REQ-024 On close, the state goes OPEN -> DONE on the next edge; ballots presented in the closing cycle are counted.
REQ-025 When close and the last ballot coincide, the result is a single transition and both are counted.
REQ-026 abstain_cnt = N - yes_cnt - no_cnt; it is computed and registered on entry to DONE, and is 0 otherwise.
REQ-027 Verdict on entry to DONE: yes_cnt > no_cnt -> O=3'b100; yes_cnt < no_cnt -> O=3'b001; equal (including 0:0) -> O=3'b010.
REQ-028 O = 3'b000 in IDLE and OPEN; yes_cnt and no_cnt are visible live during OPEN.
REQ-029 Counts never exceed N, and the timer saturates.

Reset
REQ-030 rst_n=0 forces IDLE immediately, independent of clk.
REQ-031 During reset: busy=0, done=0, all counts 0, O=3'b000, voted mask cleared, timer 0.
REQ-032 Reset asserted mid-session discards the session; no verdict is produced.
REQ-033 First start is honoured on the first rising edge after rst_n deasserts.

Verification (N=4, TIMEOUT=16)
REQ-034 start; vote_valid=4'b1111 with vote_yes=4'b0111 in one cycle -> next edge: DONE, yes=3, no=1, abstain=0, O=3'b100.
REQ-035 start; voter0 yes, then voter0 no, then voter1 no, then close -> yes=1, no=1, abstain=2, O=3'b010 (duplicate ignored).
REQ-036 start; no ballots for 16 cycles -> DONE after the 16th OPEN cycle, abstain=4, O=3'b010.
REQ-037 start; voters 2,3 no, with close in the same cycle as the voter-1 yes ballot -> yes=1, no=2, O=3'b001.
REQ-038 Reset pulse during OPEN after 2 ballots -> all outputs 0 at once; later start gives a clean session with counts from 0.
REQ-039 In DONE, assert start with vote_valid=4'b1111 -> ballots ignored that cycle, OPEN with counts 0, O=3'b000.

Source files
------------

// File: rtl/voter_tally_if.sv
// voter_tally_if: ballot inputs and tally/verdict outputs of the voter tally block
interface voter_tally_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
);
  logic          start;
  logic          close;
  logic [N-1:0]  vote_valid;
  logic [N-1:0]  vote_yes;
  logic          busy;
  logic          done;
  logic [CW-1:0] yes_cnt;
  logic [CW-1:0] no_cnt;
  logic [CW-1:0] abstain_cnt;
  logic [3:1]    O;
  modport master (
    output start, close, vote_valid, vote_yes,
    input  busy, done, yes_cnt, no_cnt, abstain_cnt, O
  );
  modport slave (
    input  start, close, vote_valid, vote_yes,
    output busy, done, yes_cnt, no_cnt, abstain_cnt, O
  );
endinterface

// File: rtl/voter_tally.sv
// voter_tally: session-based N-voter ballot tally with early close, timeout and one-hot verdict
module voter_tally #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst_n,
  voter_tally_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DONE} state_t;
  state_t        r_state, w_next;
  logic [N-1:0]  r_voted, w_new;
  logic [CW-1:0] r_yes, r_no, r_abstain, w_yes_nxt, w_no_nxt;
  logic [TW-1:0] r_timer;
  logic [3:1]    r_o, w_verdict;
  logic          w_open, w_close, w_busy, w_done;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  assign w_open    = r_state == S_OPEN;
  // only first ballots of not-yet-voted voters count, and only while open
  assign w_new     = w_open ? bus.vote_valid & ~r_voted : '0;
  assign w_yes_nxt = r_yes + popcnt(w_new & bus.vote_yes);
  assign w_no_nxt  = r_no + popcnt(w_new & ~bus.vote_yes);
  assign w_close   = bus.close || (&(r_voted | w_new)) || r_timer == TW'(TIMEOUT - 1);
  assign w_verdict = w_yes_nxt > w_no_nxt ? 3'b100 : w_yes_nxt < w_no_nxt ? 3'b001 : 3'b010;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb
    w_next = w_open ? (w_close ? S_DONE : S_OPEN) : (bus.start ? S_OPEN : r_state);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_voted   <= '0;
      r_yes     <= '0;
      r_no      <= '0;
      r_abstain <= '0;
      r_timer   <= '0;
      r_o       <= '0;
    end else if (!w_open && bus.start) begin
      r_voted   <= '0;
      r_yes     <= '0;
      r_no      <= '0;
      r_abstain <= '0;
      r_timer   <= '0;
      r_o       <= '0;
    end else if (w_open) begin
      r_voted <= r_voted | w_new;
      r_yes   <= w_yes_nxt;
      r_no    <= w_no_nxt;
      r_timer <= r_timer == TW'(TIMEOUT - 1) ? r_timer : r_timer + TW'(1);
      if (w_close) begin
        r_abstain <= CW'(N) - w_yes_nxt - w_no_nxt;
        r_o       <= w_verdict;
      end
    end

  always_comb begin
    w_busy = r_state == S_OPEN;
    w_done = r_state == S_DONE;
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.yes_cnt     = r_yes;
  assign bus.no_cnt      = r_no;
  assign bus.abstain_cnt = r_abstain;
  assign bus.O           = r_o;
endmodule
